// File: rtl/axi_lite_cut_limit.sv
// ============================================================================
//  Module   : axi_lite_cut_limit (with axi_lite_cut_limit_pkg and
//             axi_lite_cut_limit_spill)
//  Purpose  : Registered AXI-Lite cut. Every channel goes through a two-entry
//             spill buffer, and the number of accepted-but-uncompleted writes
//             and reads is each capped at MaxTrans.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

// Default AXI-Lite channel and bundle types (32-bit address and data).
package axi_lite_cut_limit_pkg;
    typedef struct packed {
        logic [31:0] addr;
        logic [2:0]  prot;
    } aw_chan_t;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  strb;
    } w_chan_t;

    typedef struct packed {
        logic [1:0] resp;
    } b_chan_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [2:0]  prot;
    } ar_chan_t;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
    } r_chan_t;

    typedef struct packed {
        aw_chan_t aw;
        logic     aw_valid;
        w_chan_t  w;
        logic     w_valid;
        logic     b_ready;
        ar_chan_t ar;
        logic     ar_valid;
        logic     r_ready;
    } req_t;

    typedef struct packed {
        logic     aw_ready;
        logic     w_ready;
        b_chan_t  b;
        logic     b_valid;
        logic     ar_ready;
        r_chan_t  r;
        logic     r_valid;
    } resp_t;
endpackage

// ----------------------------------------------------------------------------
// Two-entry spill buffer: both handshake sides are driven from registers only.
// ----------------------------------------------------------------------------
module axi_lite_cut_limit_spill #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_data
);
    logic [1:0]       r_cnt_q;
    logic [1:0]       w_cnt_d;
    logic [WIDTH-1:0] r_head_q;
    logic [WIDTH-1:0] w_head_d;
    logic [WIDTH-1:0] r_tail_q;
    logic [WIDTH-1:0] w_tail_d;
    logic             w_push;
    logic             w_pop;

    // Handshakes are masked while reset is held so no beat moves then.
    assign o_ready = !rst && (r_cnt_q != 2'd2);
    assign o_valid = !rst && (r_cnt_q != 2'd0);
    assign o_data  = r_head_q;
    assign w_push  = i_valid && o_ready;
    assign w_pop   = o_valid && i_ready;

    // Next occupancy and FIFO contents; head only moves on pop or when empty.
    always_comb begin
        w_cnt_d  = r_cnt_q;
        w_head_d = r_head_q;
        w_tail_d = r_tail_q;
        case ({w_push, w_pop})
            2'b10: begin
                w_cnt_d = r_cnt_q + 2'd1;
                if (r_cnt_q == 2'd0) begin
                    w_head_d = i_data;
                end else begin
                    w_tail_d = i_data;
                end
            end
            2'b01: begin
                w_cnt_d  = r_cnt_q - 2'd1;
                w_head_d = r_tail_q;
            end
            2'b11: begin
                // Simultaneous push and pop only happens with one entry held.
                w_head_d = i_data;
            end
            default: begin
            end
        endcase
    end

    // Occupancy register; only state that reset clears.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt_q <= 2'd0;
        end else begin
            r_cnt_q <= w_cnt_d;
        end
    end

    // Payload storage; contents are don't-care while the slot is empty.
    always_ff @(posedge clk) begin
        r_head_q <= w_head_d;
        r_tail_q <= w_tail_d;
    end
endmodule

// ----------------------------------------------------------------------------
// Top level: five spill buffers plus per-direction outstanding limiters.
// ----------------------------------------------------------------------------
module axi_lite_cut_limit #(
    parameter int unsigned AddrWidth = 32,
    parameter int unsigned DataWidth = 32,
    parameter int unsigned MaxTrans  = 4,
    parameter type         req_t     = axi_lite_cut_limit_pkg::req_t,
    parameter type         resp_t    = axi_lite_cut_limit_pkg::resp_t
) (
    input  logic  clk_i,
    input  logic  rst_i,
    input  req_t  slv_req_i,
    output resp_t slv_resp_o,
    output req_t  mst_req_o,
    input  resp_t mst_resp_i
);
    localparam int unsigned c_aw_width  = AddrWidth + 3;
    localparam int unsigned c_w_width   = DataWidth + DataWidth / 8;
    localparam int unsigned c_b_width   = 2;
    localparam int unsigned c_r_width   = DataWidth + 2;
    localparam int unsigned c_cnt_width = $clog2(MaxTrans + 1);
    localparam logic [c_cnt_width-1:0] c_cnt_max = c_cnt_width'(MaxTrans);
    localparam logic [c_cnt_width-1:0] c_cnt_one = c_cnt_width'(1);

    logic                   w_aw_in_ready, w_aw_out_valid;
    logic [c_aw_width-1:0]  w_aw_out_data;
    logic                   w_w_in_ready,  w_w_out_valid;
    logic [c_w_width-1:0]   w_w_out_data;
    logic                   w_b_in_ready,  w_b_out_valid;
    logic [c_b_width-1:0]   w_b_out_data;
    logic                   w_ar_in_ready, w_ar_out_valid;
    logic [c_aw_width-1:0]  w_ar_out_data;
    logic                   w_r_in_ready,  w_r_out_valid;
    logic [c_r_width-1:0]   w_r_out_data;

    logic [c_cnt_width-1:0] r_wr_cnt_q, w_wr_cnt_d;
    logic [c_cnt_width-1:0] r_rd_cnt_q, w_rd_cnt_d;
    logic                   w_wr_room, w_rd_room;
    logic                   w_slv_aw_ready, w_slv_ar_ready;
    logic                   w_aw_hs, w_b_hs, w_ar_hs, w_r_hs;

    // Address channels are only offered to their buffer while below the limit.
    assign w_wr_room      = (r_wr_cnt_q != c_cnt_max);
    assign w_rd_room      = (r_rd_cnt_q != c_cnt_max);
    assign w_slv_aw_ready = w_aw_in_ready && w_wr_room;
    assign w_slv_ar_ready = w_ar_in_ready && w_rd_room;
    assign w_aw_hs        = slv_req_i.aw_valid && w_slv_aw_ready;
    assign w_ar_hs        = slv_req_i.ar_valid && w_slv_ar_ready;
    assign w_b_hs         = w_b_out_valid && slv_req_i.b_ready;
    assign w_r_hs         = w_r_out_valid && slv_req_i.r_ready;

    axi_lite_cut_limit_spill #(.WIDTH(c_aw_width)) u_aw_spill (
        .clk     (clk_i),
        .rst     (rst_i),
        .i_valid (slv_req_i.aw_valid && w_wr_room),
        .o_ready (w_aw_in_ready),
        .i_data  (slv_req_i.aw),
        .o_valid (w_aw_out_valid),
        .i_ready (mst_resp_i.aw_ready),
        .o_data  (w_aw_out_data)
    );

    axi_lite_cut_limit_spill #(.WIDTH(c_w_width)) u_w_spill (
        .clk     (clk_i),
        .rst     (rst_i),
        .i_valid (slv_req_i.w_valid),
        .o_ready (w_w_in_ready),
        .i_data  (slv_req_i.w),
        .o_valid (w_w_out_valid),
        .i_ready (mst_resp_i.w_ready),
        .o_data  (w_w_out_data)
    );

    axi_lite_cut_limit_spill #(.WIDTH(c_b_width)) u_b_spill (
        .clk     (clk_i),
        .rst     (rst_i),
        .i_valid (mst_resp_i.b_valid),
        .o_ready (w_b_in_ready),
        .i_data  (mst_resp_i.b),
        .o_valid (w_b_out_valid),
        .i_ready (slv_req_i.b_ready),
        .o_data  (w_b_out_data)
    );

    axi_lite_cut_limit_spill #(.WIDTH(c_aw_width)) u_ar_spill (
        .clk     (clk_i),
        .rst     (rst_i),
        .i_valid (slv_req_i.ar_valid && w_rd_room),
        .o_ready (w_ar_in_ready),
        .i_data  (slv_req_i.ar),
        .o_valid (w_ar_out_valid),
        .i_ready (mst_resp_i.ar_ready),
        .o_data  (w_ar_out_data)
    );

    axi_lite_cut_limit_spill #(.WIDTH(c_r_width)) u_r_spill (
        .clk     (clk_i),
        .rst     (rst_i),
        .i_valid (mst_resp_i.r_valid),
        .o_ready (w_r_in_ready),
        .i_data  (mst_resp_i.r),
        .o_valid (w_r_out_valid),
        .i_ready (slv_req_i.r_ready),
        .o_data  (w_r_out_data)
    );

    // Outstanding counters: request +1, response -1, both cancel; never below 0.
    always_comb begin
        w_wr_cnt_d = r_wr_cnt_q;
        if (w_aw_hs && !w_b_hs) begin
            w_wr_cnt_d = r_wr_cnt_q + c_cnt_one;
        end else if (!w_aw_hs && w_b_hs && (r_wr_cnt_q != '0)) begin
            w_wr_cnt_d = r_wr_cnt_q - c_cnt_one;
        end
        w_rd_cnt_d = r_rd_cnt_q;
        if (w_ar_hs && !w_r_hs) begin
            w_rd_cnt_d = r_rd_cnt_q + c_cnt_one;
        end else if (!w_ar_hs && w_r_hs && (r_rd_cnt_q != '0)) begin
            w_rd_cnt_d = r_rd_cnt_q - c_cnt_one;
        end
    end

    // Counter registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wr_cnt_q <= '0;
            r_rd_cnt_q <= '0;
        end else begin
            r_wr_cnt_q <= w_wr_cnt_d;
            r_rd_cnt_q <= w_rd_cnt_d;
        end
    end

    // Reassemble both port bundles from the buffer outputs.
    always_comb begin
        slv_resp_o          = '0;
        slv_resp_o.aw_ready = w_slv_aw_ready;
        slv_resp_o.w_ready  = w_w_in_ready;
        slv_resp_o.b        = w_b_out_data;
        slv_resp_o.b_valid  = w_b_out_valid;
        slv_resp_o.ar_ready = w_slv_ar_ready;
        slv_resp_o.r        = w_r_out_data;
        slv_resp_o.r_valid  = w_r_out_valid;

        mst_req_o           = '0;
        mst_req_o.aw        = w_aw_out_data;
        mst_req_o.aw_valid  = w_aw_out_valid;
        mst_req_o.w         = w_w_out_data;
        mst_req_o.w_valid   = w_w_out_valid;
        mst_req_o.b_ready   = w_b_in_ready;
        mst_req_o.ar        = w_ar_out_data;
        mst_req_o.ar_valid  = w_ar_out_valid;
        mst_req_o.r_ready   = w_r_in_ready;
    end

`ifndef SYNTHESIS
    // A response with nothing outstanding means upstream broke the protocol.
    a_no_b_underflow : assert property (@(posedge clk_i) disable iff (rst_i)
        !(w_b_hs && (r_wr_cnt_q == '0)));
    a_no_r_underflow : assert property (@(posedge clk_i) disable iff (rst_i)
        !(w_r_hs && (r_rd_cnt_q == '0)));
`endif
endmodule

`default_nettype wire

// File: tb/tb_axi_lite_cut_limit.sv
// ============================================================================
//  Module   : tb_axi_lite_cut_limit
//  Purpose  : Self-checking bench for axi_lite_cut_limit. Two instances:
//             MaxTrans=16 (streaming, backpressure, mid-flight reset) and
//             MaxTrans=2 (limit boundary, simultaneous AW/B).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_axi_lite_cut_limit;
    import axi_lite_cut_limit_pkg::*;

    logic  clk;
    logic  rst;
    req_t  slv_req  [2];
    resp_t slv_resp [2];
    req_t  mst_req  [2];
    resp_t mst_resp [2];

    int n_checks = 0;
    int n_err    = 0;

    // Pass-through scoreboard, index = dut*5 + channel (aw, w, ar, b, r).
    logic [63:0] sb_q [10][$];

    typedef struct {
        int          dut;
        bit          aw_v;
        logic [31:0] aw_addr;
        bit          w_v;
        logic [31:0] w_data;
        bit          m_aw_rdy;
        bit          m_b_v;
        logic [1:0]  b_resp;
        bit          e_aw_rdy;
        bit          e_maw_v;
        logic [31:0] e_maw_addr;
        bit          e_b_v;
    } vec_t;

    vec_t vecs[$];

    axi_lite_cut_limit #(.MaxTrans(16)) u_dut_big (
        .clk_i      (clk),
        .rst_i      (rst),
        .slv_req_i  (slv_req[0]),
        .slv_resp_o (slv_resp[0]),
        .mst_req_o  (mst_req[0]),
        .mst_resp_i (mst_resp[0])
    );

    axi_lite_cut_limit #(.MaxTrans(2)) u_dut_small (
        .clk_i      (clk),
        .rst_i      (rst),
        .slv_req_i  (slv_req[1]),
        .slv_resp_o (slv_resp[1]),
        .mst_req_o  (mst_req[1]),
        .mst_resp_i (mst_resp[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endfunction

    function automatic void sb_pop(int idx, logic [63:0] act, string name);
        if (sb_q[idx].size() == 0) begin
            n_checks++;
            n_err++;
            $display("FAIL %s: got beat 0x%0h, expected no beat", name, act);
        end else begin
            chk(name, act, sb_q[idx].pop_front());
        end
    endfunction

    function automatic vec_t mk(int d, bit aw_v, logic [31:0] aw_addr, bit w_v,
                                logic [31:0] w_data, bit m_aw_rdy, bit m_b_v,
                                logic [1:0] b_resp, bit e_aw_rdy, bit e_maw_v,
                                logic [31:0] e_maw_addr, bit e_b_v);
        vec_t v;
        v.dut = d;          v.aw_v = aw_v;       v.aw_addr = aw_addr;
        v.w_v = w_v;        v.w_data = w_data;   v.m_aw_rdy = m_aw_rdy;
        v.m_b_v = m_b_v;    v.b_resp = b_resp;   v.e_aw_rdy = e_aw_rdy;
        v.e_maw_v = e_maw_v; v.e_maw_addr = e_maw_addr; v.e_b_v = e_b_v;
        return v;
    endfunction

    // All handshake-related outputs of one instance, in a fixed order.
    function automatic logic [9:0] outs(int d);
        return {slv_resp[d].aw_ready, slv_resp[d].w_ready, slv_resp[d].ar_ready,
                slv_resp[d].b_valid, slv_resp[d].r_valid,
                mst_req[d].aw_valid, mst_req[d].w_valid, mst_req[d].ar_valid,
                mst_req[d].b_ready, mst_req[d].r_ready};
    endfunction

    task automatic idle(int d);
        slv_req[d]          = '0;
        slv_req[d].b_ready  = 1'b1;
        slv_req[d].r_ready  = 1'b1;
        mst_resp[d]          = '0;
        mst_resp[d].aw_ready = 1'b1;
        mst_resp[d].w_ready  = 1'b1;
        mst_resp[d].ar_ready = 1'b1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor, sampled mid-cycle.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (slv_req[d].aw_valid && slv_resp[d].aw_ready)
                sb_q[d*5+0].push_back(64'(slv_req[d].aw));
            if (mst_req[d].aw_valid && mst_resp[d].aw_ready)
                sb_pop(d*5+0, 64'(mst_req[d].aw), $sformatf("dut%0d_aw_beat", d));
            if (slv_req[d].w_valid && slv_resp[d].w_ready)
                sb_q[d*5+1].push_back(64'(slv_req[d].w));
            if (mst_req[d].w_valid && mst_resp[d].w_ready)
                sb_pop(d*5+1, 64'(mst_req[d].w), $sformatf("dut%0d_w_beat", d));
            if (slv_req[d].ar_valid && slv_resp[d].ar_ready)
                sb_q[d*5+2].push_back(64'(slv_req[d].ar));
            if (mst_req[d].ar_valid && mst_resp[d].ar_ready)
                sb_pop(d*5+2, 64'(mst_req[d].ar), $sformatf("dut%0d_ar_beat", d));
            if (mst_resp[d].b_valid && mst_req[d].b_ready)
                sb_q[d*5+3].push_back(64'(mst_resp[d].b));
            if (slv_resp[d].b_valid && slv_req[d].b_ready)
                sb_pop(d*5+3, 64'(slv_resp[d].b), $sformatf("dut%0d_b_beat", d));
            if (mst_resp[d].r_valid && mst_req[d].r_ready)
                sb_q[d*5+4].push_back(64'(mst_resp[d].r));
            if (slv_resp[d].r_valid && slv_req[d].r_ready)
                sb_pop(d*5+4, 64'(slv_resp[d].r), $sformatf("dut%0d_r_beat", d));
        end
    end

    // Hard time bound so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int got_ar;
        int got_r;
        int tot;

        // Backpressure: AW beats into a stalled downstream (MaxTrans=16).
        vecs.push_back(mk(0, 1, 'h100, 0, 0, 0, 0, 2'b00, 1, 0, 0,      0));
        vecs.push_back(mk(0, 1, 'h104, 0, 0, 0, 0, 2'b00, 1, 1, 'h100, 0));
        vecs.push_back(mk(0, 1, 'h108, 0, 0, 0, 0, 2'b00, 0, 1, 'h100, 0));
        vecs.push_back(mk(0, 1, 'h108, 0, 0, 0, 0, 2'b00, 0, 1, 'h100, 0));
        vecs.push_back(mk(0, 1, 'h108, 0, 0, 1, 0, 2'b00, 0, 1, 'h100, 0));
        vecs.push_back(mk(0, 1, 'h108, 0, 0, 1, 0, 2'b00, 1, 1, 'h104, 0));
        vecs.push_back(mk(0, 0, 0,     0, 0, 1, 0, 2'b00, 1, 1, 'h108, 0));
        vecs.push_back(mk(0, 0, 0,     0, 0, 1, 0, 2'b00, 1, 0, 0,      0));
        // Limit (MaxTrans=2): third AW held off until one B completes.
        vecs.push_back(mk(1, 1, 'h10, 1, 'h11, 1, 0, 2'b00, 1, 0, 0,     0));
        vecs.push_back(mk(1, 1, 'h20, 1, 'h22, 1, 0, 2'b00, 1, 1, 'h10, 0));
        vecs.push_back(mk(1, 1, 'h30, 1, 'h33, 1, 0, 2'b00, 0, 1, 'h20, 0));
        vecs.push_back(mk(1, 1, 'h30, 0, 0,    1, 0, 2'b00, 0, 0, 0,     0));
        vecs.push_back(mk(1, 1, 'h30, 0, 0,    1, 1, 2'b01, 0, 0, 0,     0));
        vecs.push_back(mk(1, 1, 'h30, 0, 0,    1, 0, 2'b00, 0, 0, 0,     1));
        vecs.push_back(mk(1, 1, 'h30, 0, 0,    1, 0, 2'b00, 1, 0, 0,     0));
        vecs.push_back(mk(1, 0, 0,    0, 0,    1, 1, 2'b00, 0, 1, 'h30, 0));
        vecs.push_back(mk(1, 0, 0,    0, 0,    1, 1, 2'b10, 0, 0, 0,     1));
        // Simultaneous AW and B at count 1: count stays 1.
        vecs.push_back(mk(1, 1, 'h40, 1, 'h44, 1, 0, 2'b00, 1, 0, 0,     1));
        vecs.push_back(mk(1, 1, 'h50, 1, 'h55, 1, 0, 2'b00, 1, 1, 'h40, 0));
        vecs.push_back(mk(1, 0, 0,    0, 0,    1, 0, 2'b00, 0, 1, 'h50, 0));

        // ---------------- reset with every input valid ----------------
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            slv_req[d]  = '1;
            mst_resp[d] = '1;
        end
        for (int c = 0; c < 3; c++) begin
            step();
            for (int d = 0; d < 2; d++)
                chk($sformatf("reset_outputs_dut%0d_c%0d", d, c), 64'(outs(d)), 64'h0);
        end
        idle(0);
        idle(1);
        rst = 1'b0;
        #1;
        for (int d = 0; d < 2; d++)
            chk($sformatf("post_reset_outputs_dut%0d", d), 64'(outs(d)), 64'h383);
        step();

        // ---------------- streaming 16 reads ----------------
        got_ar = 0;
        got_r  = 0;
        for (int c = 0; c < 40; c++) begin
            slv_req[0].ar_valid = (c < 16);
            slv_req[0].ar.addr  = 32'(c);
            mst_resp[0].r_valid = mst_req[0].ar_valid;
            mst_resp[0].r.data  = 32'hA0 | mst_req[0].ar.addr;
            #1;
            if (mst_req[0].ar_valid && mst_resp[0].ar_ready) begin
                chk("stream_ar_cycle", 64'(c), 64'(got_ar + 1));
                chk("stream_ar_addr", 64'(mst_req[0].ar.addr), 64'(got_ar));
                got_ar++;
            end
            if (slv_resp[0].r_valid && slv_req[0].r_ready) begin
                chk("stream_r_data", 64'(slv_resp[0].r.data), 64'(32'hA0 + got_r));
                got_r++;
            end
            step();
            if (got_r == 16) break;
        end
        chk("stream_ar_count", 64'(got_ar), 64'd16);
        chk("stream_r_count", 64'(got_r), 64'd16);
        idle(0);
        step();

        // ---------------- table: backpressure, limit, simultaneous ----------------
        foreach (vecs[i]) begin
            int d;
            d = vecs[i].dut;
            idle(0);
            idle(1);
            slv_req[d].aw_valid  = vecs[i].aw_v;
            slv_req[d].aw.addr   = vecs[i].aw_addr;
            slv_req[d].w_valid   = vecs[i].w_v;
            slv_req[d].w.data    = vecs[i].w_data;
            slv_req[d].w.strb    = 4'hF;
            mst_resp[d].aw_ready = vecs[i].m_aw_rdy;
            mst_resp[d].b_valid  = vecs[i].m_b_v;
            mst_resp[d].b.resp   = vecs[i].b_resp;
            #1;
            chk($sformatf("vec%0d_slv_aw_ready", i), 64'(slv_resp[d].aw_ready), 64'(vecs[i].e_aw_rdy));
            chk($sformatf("vec%0d_mst_aw_valid", i), 64'(mst_req[d].aw_valid), 64'(vecs[i].e_maw_v));
            if (vecs[i].e_maw_v)
                chk($sformatf("vec%0d_mst_aw_addr", i), 64'(mst_req[d].aw.addr), 64'(vecs[i].e_maw_addr));
            chk($sformatf("vec%0d_slv_b_valid", i), 64'(slv_resp[d].b_valid), 64'(vecs[i].e_b_v));
            step();
        end
        idle(0);
        idle(1);
        step();

        // ---------------- reset mid-flight ----------------
        slv_req[0].aw_valid  = 1'b1;
        slv_req[0].aw.addr   = 32'h200;
        mst_resp[0].aw_ready = 1'b0;
        mst_resp[0].r_valid  = 1'b1;
        mst_resp[0].r.data   = 32'h5A;
        slv_req[0].r_ready   = 1'b0;
        step();
        slv_req[0].aw.addr   = 32'h204;
        mst_resp[0].r_valid  = 1'b0;
        step();
        slv_req[0].aw_valid  = 1'b0;
        #1;
        chk("midflight_aw_buffered", 64'(mst_req[0].aw_valid), 64'd1);
        chk("midflight_r_buffered", 64'(slv_resp[0].r_valid), 64'd1);
        chk("midflight_small_aw_blocked", 64'(slv_resp[1].aw_ready), 64'd0);
        rst = 1'b1;
        #1;
        chk("midflight_reset_outputs", 64'(outs(0)), 64'h0);
        for (int i = 0; i < 10; i++) sb_q[i].delete();
        step();
        rst = 1'b0;
        idle(0);
        idle(1);
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("after_reset_no_aw_c%0d", c), 64'(mst_req[0].aw_valid), 64'd0);
            chk($sformatf("after_reset_no_r_c%0d", c), 64'(slv_resp[0].r_valid), 64'd0);
            step();
        end
        chk("after_reset_small_aw_ready", 64'(slv_resp[1].aw_ready), 64'd1);
        chk("after_reset_wr_cnt", 64'(u_dut_big.r_wr_cnt_q), 64'd0);
        chk("after_reset_rd_cnt", 64'(u_dut_big.r_rd_cnt_q), 64'd0);

        tot = 0;
        for (int i = 0; i < 10; i++) tot += sb_q[i].size();
        chk("scoreboard_drained", 64'(tot), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule

`default_nettype wire
